and_result_checker: RTL and testbench
=====================================

Name: and_result_checker

Overview:
- Downstream checking stage for the two-input AND blocks (the Verilog-style and SystemVerilog-style variants).
- Accepts vectors over a valid/ready handshake. Each vector carries the applied inputs a, b and both DUT outputs y1, y2.
- Computes the expected value a && b, compares both outputs against it, and accumulates pass/fail statistics over a run of NUM_VEC vectors.
- Reports a run verdict to the bench or a status register.

Parameters:
- NUM_VEC, 4: number of vectors per run. Range 1..2^VEC_W-1.
- VEC_W, 8: width of the vector index and vector counter.
- ERR_W, 8: width of the error counter. The counter saturates.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a run from IDLE or DONE
- vec_valid  input  1  vector present on a/b/y1/y2
- vec_ready  output  1  checker accepts a vector this cycle
- a  input  1  applied input a
- b  input  1  applied input b
- y1  input  1  output of DUT instance 1
- y2  input  1  output of DUT instance 2
- busy  output  1  run in progress
- done  output  1  run complete; held until next start or reset
- pass  output  1  valid when done=1; 1 iff err_cnt==0
- vec_cnt  output  VEC_W  number of vectors compared so far this run
- err_cnt  output  ERR_W  number of failing vectors; saturates at 2^ERR_W-1
- first_err_valid  output  1  at least one failure this run
- first_err_idx  output  VEC_W  0-based index of the first failing vector

Behaviour:
- Reset is asynchronous assert, synchronous deassert at the next clk edge. During and after reset:
  - state=IDLE
  - vec_ready=0, busy=0, done=0, pass=0
  - vec_cnt=0, err_cnt=0, first_err_valid=0, first_err_idx=0
  - capture stage invalid
- FSM states:
  - IDLE: outputs at reset values. start -> RUN. Counters and first_err fields clear on the same edge.
  - RUN: busy=1. vec_ready=1 while accepted count < NUM_VEC. When NUM_VEC vectors are accepted and the capture stage is empty, the next edge goes to DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0); counters frozen. start -> RUN with counters cleared and done dropped on the same edge.
- Handshake: a transfer occurs on an edge where vec_valid && vec_ready. a/b/y1/y2 are registered into the capture stage. vec_valid may be deasserted for any number of cycles; gaps have no effect.
- Compare is 1-cycle pipelined. The cycle after a transfer:
  - expected = a & b
  - fail = (y1 != expected) | (y2 != expected)
  - vec_cnt increments on the next edge
  - if fail: err_cnt increments (unless saturated). If first_err_valid=0, first_err_idx is set to the pre-increment vec_cnt and first_err_valid is set to 1.
- Back-to-back transfers are sustained at 1 vector/cycle.
- done asserts on the edge after the last compare updates counters. Latency from the last transfer to done=1 is 2 cycles.
- start is ignored while in RUN.
- vec_valid is ignored in IDLE and DONE; vec_ready=0 there.
- err_cnt holds at 2^ERR_W-1 on further failures; pass stays 0.
- Reset mid-run aborts immediately to IDLE and discards any captured vector.

Test Plan:
- All four truth-table vectors (00, 01, 10, 11), both DUTs correct, back-to-back after start:
  - vec_cnt=4, err_cnt=0, pass=1, first_err_valid=0
  - done rises 2 cycles after the 4th transfer
- Same vectors with y2 forced 0 on vector 11:
  - err_cnt=1, first_err_valid=1, first_err_idx=3, pass=0
- Both DUTs wrong on vectors 0 and 2:
  - err_cnt=2, first_err_idx=0
- vec_valid with random 0–3 cycle gaps:
  - identical final counts to back-to-back
  - no transfer while vec_ready=0
- start pulsed in mid-RUN:
  - ignored
- start from DONE:
  - counters clear, done drops next cycle, second run yields independent results
- rst_n low after vector 2 of a run:
  - all outputs return to reset values asynchronously
  - after release, a new start runs cleanly to vec_cnt=4
- NUM_VEC=255, ERR_W=4, every vector failing:
  - err_cnt saturates at 15, vec_cnt=255, pass=0

Source files
------------

// File: rtl/and_result_checker.sv
// and_result_checker: checks both AND-gate DUT outputs against a & b over
// a run of NUM_VEC vectors and reports counts, first error and verdict.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             pulse; begins a run from IDLE or DONE
//   vec_valid/ready   vector handshake carrying a, b, y1, y2
//   busy, done, pass  run status; pass valid while done=1
//   vec_cnt, err_cnt  compared / failing vector counts (err saturates)
//   first_err_valid   a failure has been seen this run
//   first_err_idx     0-based index of the first failing vector
module and_result_checker #(
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned VEC_W   = 8,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             a,
  input  logic             b,
  input  logic             y1,
  input  logic             y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [VEC_W-1:0] vec_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [VEC_W-1:0] LAST = VEC_W'(NUM_VEC);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t state;
  state_t state_nx;

  logic [VEC_W-1:0] acc_cnt;
  logic             cap_vld;
  logic             cap_a;
  logic             cap_b;
  logic             cap_y1;
  logic             cap_y2;

  logic all_in;
  logic xfer;
  logic fail;
  logic clr;
  logic expv;

  assign all_in    = (acc_cnt == LAST);
  assign vec_ready = (state == RUN) && !all_in;
  assign xfer      = vec_valid && vec_ready;
  assign clr       = start && (state != RUN);

  assign expv = cap_a & cap_b;
  assign fail = (cap_y1 != expv) || (cap_y2 != expv);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Leave RUN only once the last captured vector has been compared.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (all_in && !cap_vld) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt         <= '0;
      cap_vld         <= 1'b0;
      cap_a           <= 1'b0;
      cap_b           <= 1'b0;
      cap_y1          <= 1'b0;
      cap_y2          <= 1'b0;
      vec_cnt         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (clr) begin
      acc_cnt         <= '0;
      cap_vld         <= 1'b0;
      vec_cnt         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      cap_vld <= xfer;
      if (xfer) begin
        acc_cnt <= acc_cnt + 1'b1;
        cap_a   <= a;
        cap_b   <= b;
        cap_y1  <= y1;
        cap_y2  <= y2;
      end
      if (cap_vld) begin
        vec_cnt <= vec_cnt + 1'b1;
        if (fail) begin
          if (err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + 1'b1;
          end
          // Index is the pre-increment count.
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= vec_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_and_result_checker.sv
// tb_and_result_checker: randomized scoreboard bench for
// and_result_checker, plus a saturation run on a second instance.
module tb_and_result_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       y1 = 1'b0;
  logic       y2 = 1'b0;
  logic       vec_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] vec_cnt;
  logic [7:0] err_cnt;
  logic       first_err_valid;
  logic [7:0] first_err_idx;

  logic       s_start = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_a = 1'b0;
  logic       s_b = 1'b0;
  logic       s_y1 = 1'b0;
  logic       s_y2 = 1'b0;
  logic       s_ready;
  logic       s_busy;
  logic       s_done;
  logic       s_pass;
  logic [7:0] s_vec_cnt;
  logic [3:0] s_err_cnt;
  logic       s_fev;
  logic [7:0] s_fei;

  and_result_checker #(
    .NUM_VEC(4), .VEC_W(8), .ERR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .a(a), .b(b), .y1(y1), .y2(y2),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx)
  );

  and_result_checker #(
    .NUM_VEC(255), .VEC_W(8), .ERR_W(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .vec_valid(s_valid), .vec_ready(s_ready),
    .a(s_a), .b(s_b), .y1(s_y1), .y2(s_y2),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt),
    .first_err_valid(s_fev),
    .first_err_idx(s_fei)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int cnt;
    int err;
    bit fev;
    int fei;
    bit pass;
  } exp_t;

  exp_t vec_q[$];
  exp_t run_q[$];

  int m_n;
  int m_errs;
  int m_first;
  int last_xfer;

  task automatic model_reset();
    m_n = 0;
    m_errs = 0;
    m_first = -1;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt  = m_n;
    e.err  = (m_errs > 255) ? 255 : m_errs;
    e.fev  = (m_first >= 0);
    e.fei  = e.fev ? m_first : 0;
    e.pass = (m_errs == 0);
    return e;
  endfunction

  // Per-vector and per-run scoreboard monitor.
  int prev_cnt = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (int'(vec_cnt) == prev_cnt + 1) begin
        if (vec_q.size() == 0) begin
          chk("vec_q_empty", 1, 0);
        end else begin
          e = vec_q.pop_front();
          chk("step_vec_cnt", vec_cnt, e.cnt);
          chk("step_err_cnt", err_cnt, e.err);
          chk("step_fev", first_err_valid, e.fev);
          chk("step_fei", first_err_idx, e.fei);
        end
      end
      prev_cnt = int'(vec_cnt);
      if (done && !prev_done) begin
        if (run_q.size() == 0) begin
          chk("run_q_empty", 1, 0);
        end else begin
          e = run_q.pop_front();
          chk("run_vec_cnt", vec_cnt, e.cnt);
          chk("run_err_cnt", err_cnt, e.err);
          chk("run_pass", pass, e.pass);
          chk("run_fev", first_err_valid, e.fev);
          chk("run_fei", first_err_idx, e.fei);
          chk("run_busy", busy, 0);
          chk("done_latency", cyc - last_xfer, 2);
        end
      end
      prev_done = done;
    end
  end

  task automatic check_reset_vals();
    chk("rst_ready", vec_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fev", first_err_valid, 0);
    chk("rst_fei", first_err_idx, 0);
  endtask

  task automatic do_start();
    bit was_done;
    @(negedge clk);
    was_done = done;
    start = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_vec_cnt", vec_cnt, 0);
    chk("start_err_cnt", err_cnt, 0);
    chk("start_fev", first_err_valid, 0);
    if (was_done) chk("start_done_drop", done, 0);
  endtask

  task automatic send(bit ia, bit ib, bit iy1, bit iy2, int gap);
    int w = 0;
    bit ey;
    repeat (gap) begin
      @(negedge clk);
      vec_valid = 1'b0;
    end
    @(negedge clk);
    vec_valid = 1'b1;
    a = ia;
    b = ib;
    y1 = iy1;
    y2 = iy2;
    while (!vec_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!vec_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_xfer = cyc;
    ey = ia & ib;
    if (iy1 != ey || iy2 != ey) begin
      if (m_first < 0) m_first = m_n;
      m_errs++;
    end
    m_n++;
    vec_q.push_back(snapshot());
  endtask

  // vec_valid stays high into DONE: no further vectors may be taken.
  task automatic end_run();
    int w = 0;
    run_q.push_back(snapshot());
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    @(negedge clk);
    chk("frozen_vec_cnt", vec_cnt, m_n);
    chk("done_ready", vec_ready, 0);
    vec_valid = 1'b0;
  endtask

  task automatic truth_run(int bad, int gapmax);
    bit ya;
    bit yb;
    for (int i = 0; i < 4; i++) begin
      ya = ((i >> 1) & 1) & (i & 1);
      yb = ya;
      if (bad == 1 && i == 3) yb = 1'b0;
      if (bad == 2 && (i == 0 || i == 2)) begin
        ya = ~ya;
        yb = ~yb;
      end
      send(bit'((i >> 1) & 1), bit'(i & 1), ya, yb,
           (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit ra;
    bit rb;
    bit ry;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // vec_valid in IDLE is ignored.
    vec_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", vec_ready, 0);
    chk("idle_vec_cnt", vec_cnt, 0);
    vec_valid = 1'b0;

    do_start(); truth_run(0, 0); end_run();
    do_start(); truth_run(1, 0); end_run();
    do_start(); truth_run(2, 0); end_run();
    do_start(); truth_run(1, 3); end_run();
    do_start(); truth_run(0, 3); end_run();

    for (int r = 0; r < 6; r++) begin
      do_start();
      for (int i = 0; i < 4; i++) begin
        ra = 1'($urandom);
        rb = 1'($urandom);
        ry = ra & rb;
        send(ra, rb,
             ($urandom_range(0, 3) == 0) ? ~ry : ry,
             ($urandom_range(0, 3) == 0) ? ~ry : ry,
             $urandom_range(0, 3));
      end
      end_run();
    end

    // start in RUN is ignored.
    do_start();
    send(1, 1, 1, 1, 0);
    send(0, 1, 1, 0, 0);
    @(negedge clk);
    vec_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_start_busy", busy, 1);
    chk("mid_start_vec_cnt", vec_cnt, 2);
    chk("mid_start_err_cnt", err_cnt, 1);
    send(1, 0, 0, 0, 1);
    send(0, 0, 0, 0, 0);
    end_run();

    // Reset mid-run.
    do_start();
    send(1, 1, 1, 1, 0);
    send(1, 0, 1, 1, 0);
    @(negedge clk);
    vec_valid = 1'b0;
    w = 0;
    while (vec_cnt != 8'd2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("pre_reset_vec_cnt", vec_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals();
    do_start(); truth_run(2, 1); end_run();

    // Saturation on the 255-vector / 4-bit error instance.
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    s_a = 1'b1;
    s_b = 1'b1;
    w = 0;
    while (!s_done && w < 400) begin
      @(negedge clk);
      if (s_vec_cnt == 8'd100) chk("sat_hold", s_err_cnt, 15);
      w++;
    end
    chk("sat_done", s_done, 1);
    chk("sat_vec_cnt", s_vec_cnt, 255);
    chk("sat_err_cnt", s_err_cnt, 15);
    chk("sat_pass", s_pass, 0);
    chk("sat_fev", s_fev, 1);
    chk("sat_fei", s_fei, 0);
    chk("sat_busy", s_busy, 0);
    chk("sat_ready", s_ready, 0);
    s_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("vec_q_drained", vec_q.size(), 0);
    chk("run_q_drained", run_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
